// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: writeback source selects
// and load funct3 encodings.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; unknown funct3 passes the word through.
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   aligned = {{16{half_sel[15]}}, half_sel};
      F3_LW:   aligned = word;
      F3_LBU:  aligned = {24'h0, byte_sel};
      F3_LHU:  aligned = {16'h0, half_sel};
      default: aligned = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, one-entry buffer for
// long-latency results and the register-file write port arbiter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [31:0] mem_pc_plus4,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        stall_req,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  // MEM/WB pipeline register
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  wb_sel_e     wb_sel;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;
  logic [31:0] wb_alu;
  logic [31:0] wb_load;
  logic [31:0] wb_pc4;

  // Long-latency result buffer and its starvation counter
  logic [4:0]    pend_rd_q;
  logic [31:0]   pend_data;
  logic [CW-1:0] starve_cnt;

  logic [31:0] load_value;
  logic [31:0] wb_value;
  logic        wb_wr;
  logic        force_wr;
  logic        drain;

  load_align u_load_align (
    .funct3  (wb_funct3),
    .addr_lo (wb_addr_lo),
    .word    (wb_load),
    .aligned (load_value)
  );

  // Pipeline register: captures MEM outputs unless a forced drain stalls it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_sel       <= WB_ALU;
      wb_funct3    <= '0;
      wb_addr_lo   <= '0;
      wb_alu       <= '0;
      wb_load      <= '0;
      wb_pc4       <= '0;
    end else if (!stall_req) begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_rd        <= mem_rd;
      wb_sel       <= wb_sel_e'(mem_wb_sel);
      wb_funct3    <= mem_funct3;
      wb_addr_lo   <= mem_addr_lo;
      wb_alu       <= mem_alu_result;
      wb_load      <= mem_load_data;
      wb_pc4       <= mem_pc_plus4;
    end
  end

  // Buffer: fills on handshake, empties when the arbiter drains it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rd_q  <= '0;
      pend_data  <= '0;
    end else if (drain) begin
      pend_valid <= 1'b0;
    end else if (lu_valid && lu_ready) begin
      pend_valid <= 1'b1;
      pend_rd_q  <= lu_rd;
      pend_data  <= lu_data;
    end
  end

  // Counts arbitration losses of the buffered result, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (drain) begin
      starve_cnt <= '0;
    end else if (pend_valid && wb_wr && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Writeback source mux; the reserved select behaves as ALU.
  always_comb begin
    case (wb_sel)
      WB_LOAD: wb_value = load_value;
      WB_PC4:  wb_value = wb_pc4;
      default: wb_value = wb_alu;
    endcase
  end

  assign wb_wr    = wb_valid && wb_reg_write && (wb_rd != 5'd0);
  assign force_wr = pend_valid && (starve_cnt == CNT_MAX);

  // Write port arbiter: forced drain, then pipeline, then idle-slot drain.
  always_comb begin
    RegWrite   = 1'b0;
    rd         = '0;
    write_data = '0;
    drain      = 1'b0;
    if (force_wr || (!wb_wr && pend_valid)) begin
      drain = 1'b1;
      if (pend_rd_q != 5'd0) begin
        RegWrite   = 1'b1;
        rd         = pend_rd_q;
        write_data = pend_data;
      end
    end else if (wb_wr) begin
      RegWrite   = 1'b1;
      rd         = wb_rd;
      write_data = wb_value;
    end
  end

  assign stall_req = force_wr;
  assign lu_ready  = !pend_valid;
  assign pend_rd   = pend_valid ? pend_rd_q : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level model.
module tb_wb_stage;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        stall_req, pend_valid;
  logic [4:0]  pend_rd;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;

  always #5 clk = ~clk;

  wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_addr_lo    (mem_addr_lo),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .lu_valid       (lu_valid),
    .lu_ready       (lu_ready),
    .lu_rd          (lu_rd),
    .lu_data        (lu_data),
    .stall_req      (stall_req),
    .pend_valid     (pend_valid),
    .pend_rd        (pend_rd),
    .RegWrite       (RegWrite),
    .rd             (rd),
    .write_data     (write_data)
  );

  typedef struct {
    logic        v, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu, ld, pc4;
  } mem_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        stall, ready, pv;
    logic [4:0]  prd;
  } out_t;

  // Reference model state: the WB entry holds its already-resolved value.
  bit          m_wbv, m_wbrw;
  logic [4:0]  m_wbrd  = '0;
  logic [31:0] m_wbval = '0;
  bit          m_pend;
  logic [4:0]  m_prd   = '0;
  logic [31:0] m_pdata = '0;
  int unsigned m_lost;
  mem_t        last_m;
  bit          hold;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] lo, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_value(mem_t m);
    case (m.sel)
      2'b01:   return ref_load(m.f3, m.lo, m.ld);
      2'b10:   return m.pc4;
      default: return m.alu;
    endcase
  endfunction

  function automatic out_t ref_out();
    out_t o;
    bit pipe_wr;
    pipe_wr = m_wbv && m_wbrw && (m_wbrd != 5'd0);
    o.rw = 1'b0; o.rd = '0; o.wd = '0;
    o.stall = m_pend && (m_lost == MAX_WAIT);
    o.ready = !m_pend;
    o.pv    = m_pend;
    o.prd   = m_pend ? m_prd : 5'd0;
    if (o.stall || (m_pend && !pipe_wr)) begin
      if (m_prd != 5'd0) begin o.rw = 1'b1; o.rd = m_prd; o.wd = m_pdata; end
    end else if (pipe_wr) begin
      o.rw = 1'b1; o.rd = m_wbrd; o.wd = m_wbval;
    end
    return o;
  endfunction

  function automatic mem_t mk(logic v, logic rw, logic [4:0] r, logic [1:0] sel,
                              logic [2:0] f3, logic [1:0] lo, logic [31:0] alu,
                              logic [31:0] ld, logic [31:0] pc4);
    mem_t m;
    m.v = v; m.rw = rw; m.rd = r; m.sel = sel; m.f3 = f3; m.lo = lo;
    m.alu = alu; m.ld = ld; m.pc4 = pc4;
    return m;
  endfunction

  function automatic mem_t bubble();
    return mk(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic mem_t alu_op(logic [4:0] r, logic [31:0] val);
    return mk(1'b1, 1'b1, r, 2'b00, 3'b000, 2'b00, val, 32'h0, 32'h0);
  endfunction

  task automatic check_model();
    out_t o;
    o = ref_out();
    check("RegWrite",   {31'h0, RegWrite},   {31'h0, o.rw});
    check("rd",         {27'h0, rd},         {27'h0, o.rd});
    check("write_data", write_data,          o.wd);
    check("stall_req",  {31'h0, stall_req},  {31'h0, o.stall});
    check("lu_ready",   {31'h0, lu_ready},   {31'h0, o.ready});
    check("pend_valid", {31'h0, pend_valid}, {31'h0, o.pv});
    check("pend_rd",    {27'h0, pend_rd},    {27'h0, o.prd});
  endtask

  // One clock: drive at negedge, advance the model across the edge, then
  // compare every output shortly after the edge.
  task automatic step(input mem_t m_in, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ldat);
    out_t o;
    bit pipe_wr;
    mem_t m;
    m = m_in;
    @(negedge clk);
    if (hold) m = last_m;
    mem_valid = m.v; mem_reg_write = m.rw; mem_rd = m.rd; mem_wb_sel = m.sel;
    mem_funct3 = m.f3; mem_addr_lo = m.lo; mem_alu_result = m.alu;
    mem_load_data = m.ld; mem_pc_plus4 = m.pc4;
    lu_valid = lv; lu_rd = lrd; lu_data = ldat;
    last_m = m;

    o = ref_out();
    pipe_wr = m_wbv && m_wbrw && (m_wbrd != 5'd0);
    hold = 1'b0;
    if (!rst_n) begin
      m_wbv = 1'b0; m_pend = 1'b0; m_lost = 0;
    end else if (o.stall) begin
      m_pend = 1'b0; m_lost = 0; hold = 1'b1;
    end else begin
      if (m_pend && pipe_wr) m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT;
      else if (m_pend) begin m_pend = 1'b0; m_lost = 0; end
      else if (lv) begin m_pend = 1'b1; m_prd = lrd; m_pdata = ldat; m_lost = 0; end
      m_wbv = m.v; m_wbrw = m.rw; m_wbrd = m.rd; m_wbval = ref_value(m);
    end
    @(posedge clk);
    #2;
    check_model();
  endtask

  task automatic idle();
    step(bubble(), 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    mem_t m;
    rst_n = 1'b0;
    last_m = bubble();
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_wb_sel = 0; mem_funct3 = 0;
    mem_addr_lo = 0; mem_alu_result = 0; mem_load_data = 0; mem_pc_plus4 = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;

    idle(); idle();
    check("rst_RegWrite",   {31'h0, RegWrite},   32'h0);
    check("rst_write_data", write_data,          32'h0);
    check("rst_lu_ready",   {31'h0, lu_ready},   32'h1);
    check("rst_pend_valid", {31'h0, pend_valid}, 32'h0);
    rst_n = 1'b1;
    idle();

    // Load alignment
    step(mk(1, 1, 5'd5, 2'b01, 3'b000, 2'b00, 32'h0, 32'h1234_80FF, 32'h0), 0, 0, 0);
    check("lb_rd",   {27'h0, rd}, 32'd5);
    check("lb_data", write_data,  32'hFFFF_FFFF);
    step(mk(1, 1, 5'd6, 2'b01, 3'b100, 2'b11, 32'h0, 32'h1234_80FF, 32'h0), 0, 0, 0);
    check("lbu_data", write_data, 32'h0000_0012);
    step(mk(1, 1, 5'd8, 2'b01, 3'b001, 2'b10, 32'h0, 32'h1234_80FF, 32'h0), 0, 0, 0);
    check("lh_data", write_data, 32'h0000_1234);

    // x0 suppression
    step(alu_op(5'd0, 32'h55), 0, 0, 0);
    check("x0_pipe", {31'h0, RegWrite}, 32'h0);
    step(bubble(), 1'b1, 5'd0, 32'hAAAA_AAAA);
    check("x0_buf_we",  {31'h0, RegWrite},   32'h0);
    check("x0_buf_pv",  {31'h0, pend_valid}, 32'h1);
    idle();
    check("x0_drained", {31'h0, lu_ready},   32'h1);

    // Bubble drain
    step(bubble(), 1'b1, 5'd7, 32'hDEAD_BEEF);
    check("bub_rd",   {27'h0, rd}, 32'd7);
    check("bub_data", write_data,  32'hDEAD_BEEF);
    idle();
    check("bub_pv_once", {31'h0, pend_valid}, 32'h0);

    // Pipeline priority
    step(alu_op(5'd10, 32'h100), 1'b1, 5'd9, 32'h999);
    check("pri_rd1", {27'h0, rd}, 32'd10);
    step(alu_op(5'd11, 32'h101), 0, 0, 0);
    check("pri_rd2", {27'h0, rd}, 32'd11);
    idle();
    check("pri_buf", {27'h0, rd}, 32'd9);
    check("pri_nostall", {31'h0, stall_req}, 32'h0);
    idle();

    // Starvation: four lost slots, then a forced drain with the entry held
    step(alu_op(5'd12, 32'h112), 1'b1, 5'd9, 32'h900);
    for (int unsigned r = 13; r <= 16; r++) step(alu_op(5'(r), 32'h100 + r), 0, 0, 0);
    check("stv_stall", {31'h0, stall_req}, 32'h1);
    check("stv_rd",    {27'h0, rd},        32'd9);
    check("stv_data",  write_data,         32'h900);
    step(alu_op(5'd17, 32'h117), 0, 0, 0);
    check("stv_held",  {27'h0, rd},        32'd16);
    check("stv_one",   {31'h0, stall_req}, 32'h0);
    step(alu_op(5'd17, 32'h117), 0, 0, 0);
    check("stv_next",  {27'h0, rd},        32'd17);
    idle();

    // Reset mid-operation
    step(alu_op(5'd20, 32'h120), 1'b1, 5'd21, 32'h121);
    step(alu_op(5'd22, 32'h122), 0, 0, 0);
    rst_n = 1'b0;
    idle();
    check("mrst_we", {31'h0, RegWrite},   32'h0);
    check("mrst_pv", {31'h0, pend_valid}, 32'h0);
    rst_n = 1'b1;
    idle();
    check("mrst_nowrite", {31'h0, RegWrite}, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      m.v   = ($urandom_range(0, 99) < 80);
      m.rw  = ($urandom_range(0, 99) < 85);
      m.rd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      m.sel = 2'($urandom_range(0, 3));
      m.f3  = 3'($urandom_range(0, 7));
      m.lo  = 2'($urandom_range(0, 3));
      m.alu = $urandom; m.ld = $urandom; m.pc4 = $urandom;
      step(m, ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
